axis_demux: RTL

// - 1-to-4 AXI-Stream router. Inverse of the 4-to-1 stream select in the correlation datapath.
// - Routes frames of FRAME_LEN beats from indata to one of outdata_1..4, chosen by Demux_Sel.
// - Fully registered: a 2-entry elastic buffer gives 1-cycle latency, 1 beat/clk throughput, and
//   no combinational tready path from outputs to input.

---
 rtl/axis_demux.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/axis_demux.sv
// 1-to-4 AXI-Stream frame router. Demux_Sel is sampled on the first beat of each frame.
// A two-entry elastic buffer (main + skid) registers every output and the input tready.
module axis_demux #(
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [1:0]            Demux_Sel,

  input  logic [DATA_WIDTH-1:0] indata_tdata,
  input  logic                  indata_tvalid,
  output logic                  indata_tready,

  output logic [DATA_WIDTH-1:0] outdata_1_tdata,
  output logic                  outdata_1_tvalid,
  input  logic                  outdata_1_tready,

  output logic [DATA_WIDTH-1:0] outdata_2_tdata,
  output logic                  outdata_2_tvalid,
  input  logic                  outdata_2_tready,

  output logic [DATA_WIDTH-1:0] outdata_3_tdata,
  output logic                  outdata_3_tvalid,
  input  logic                  outdata_3_tready,

  output logic [DATA_WIDTH-1:0] outdata_4_tdata,
  output logic                  outdata_4_tvalid,
  input  logic                  outdata_4_tready,

  output logic                  Frame_Busy,
  output logic                  Frame_Done
);

  localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_LEN - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            route_q, route_d;
  logic                  main_vld_q, main_vld_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [1:0]            main_dest_q, main_dest_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [1:0]            skid_dest_q, skid_dest_d;
  logic                  in_rdy_q, in_rdy_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  in_hs;
  logic [1:0]            in_dest;
  logic [3:0]            out_rdy;
  logic                  drain;

  assign out_rdy = {outdata_4_tready, outdata_3_tready, outdata_2_tready, outdata_1_tready};
  assign in_hs   = indata_tvalid & in_rdy_q;
  assign in_dest = (cnt_q == '0) ? Demux_Sel : route_q;
  assign drain   = main_vld_q & out_rdy[main_dest_q];

  always_comb begin
    cnt_d       = cnt_q;
    route_d     = route_q;
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_dest_d = main_dest_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_dest_d = skid_dest_q;
    done_d      = 1'b0;

    if (in_hs) begin
      if (cnt_q == '0) begin
        route_d = Demux_Sel;
      end
      if (cnt_q == CntLast) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    // in_rdy_q is low whenever skid is full, so skid refill and input accept never collide
    if (!main_vld_q || drain) begin
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = skid_data_q;
        main_dest_d = skid_dest_q;
        skid_vld_d  = 1'b0;
      end else if (in_hs) begin
        main_vld_d  = 1'b1;
        main_data_d = indata_tdata;
        main_dest_d = in_dest;
      end else begin
        main_vld_d  = 1'b0;
      end
    end else if (in_hs) begin
      skid_vld_d  = 1'b1;
      skid_data_d = indata_tdata;
      skid_dest_d = in_dest;
    end

    in_rdy_d = ~skid_vld_d;
    busy_d   = (cnt_d != '0);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q       <= '0;
      route_q     <= '0;
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_dest_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_dest_q <= '0;
      in_rdy_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      route_q     <= route_d;
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      main_dest_q <= main_dest_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_dest_q <= skid_dest_d;
      in_rdy_q    <= in_rdy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign indata_tready = in_rdy_q;
  assign Frame_Busy    = busy_q;
  assign Frame_Done    = done_q;

  assign outdata_1_tdata  = main_data_q;
  assign outdata_2_tdata  = main_data_q;
  assign outdata_3_tdata  = main_data_q;
  assign outdata_4_tdata  = main_data_q;
  assign outdata_1_tvalid = main_vld_q && (main_dest_q == 2'd0);
  assign outdata_2_tvalid = main_vld_q && (main_dest_q == 2'd1);
  assign outdata_3_tvalid = main_vld_q && (main_dest_q == 2'd2);
  assign outdata_4_tvalid = main_vld_q && (main_dest_q == 2'd3);

endmodule
